serial_tx_fifo: RTL and testbench

Byte FIFO and frame pacer sitting directly upstream of the SERIAL_TX UART transmitter. It accepts demodulated bytes from the modem receive path in single-cycle writes, buffers them, and presents them one at a time to SERIAL_TX as a stable DATA byte plus a one-cycle EN strobe. SERIAL_TX has no busy output, so the block guarantees a full frame time between strobes.

---
 rtl/serial_tx_fifo.sv | 135 +++++++++++++
 tb/tb_serial_tx_fifo.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_fifo.sv
// Byte FIFO plus frame pacer feeding SERIAL_TX: one TX_EN strobe at most every GAP_CYCLES+3 cycles.
// Optional FLUSH input is built only when TXFIFO_FLUSH_EN is defined.
module serial_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter logic [15:0] GAP_CYCLES = 16'd62520
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [7:0]            WR_DATA,
  input  logic                  WR_EN,
`ifdef TXFIFO_FLUSH_EN
  input  logic                  FLUSH,
`endif
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [DEPTH_LOG2:0]   LEVEL,
  output logic                  OVERFLOW,
  output logic [7:0]            TX_DATA,
  output logic                  TX_EN
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT} state_t;

  state_t                r_state;
  logic [15:0]           r_cnt;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_ovf;
  logic [7:0]            r_tx_data;
  logic                  r_tx_en;

  logic w_full;
  logic w_empty;
  logic w_flush;
  logic w_push;
  logic w_pop;

`ifdef TXFIFO_FLUSH_EN
  assign w_flush = FLUSH;
`else
  assign w_flush = 1'b0;
`endif

  assign w_full  = (r_level == LVL_FULL);
  assign w_empty = (r_level == '0);
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  // Fullness is judged before any same-cycle pop, so a write into a full FIFO is always dropped.
  assign w_push  = WR_EN && !w_full && !w_flush;

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      if (WR_EN && w_full) begin
        r_ovf <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Pacer state, wait counter and TX_DATA ignore FLUSH so an in-flight frame keeps its gap.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_tx_data <= 8'h00;
      r_tx_en   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_tx_data <= r_mem[r_rptr];
            r_tx_en   <= 1'b1;
            r_state   <= S_STROBE;
          end
        end
        S_STROBE: begin
          r_tx_en <= 1'b0;
          r_cnt   <= GAP_CYCLES;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx_en <= 1'b0;
        end
      endcase
    end
  end

  assign FULL     = w_full;
  assign EMPTY    = w_empty;
  assign LEVEL    = r_level;
  assign OVERFLOW = r_ovf;
  assign TX_DATA  = r_tx_data;
  assign TX_EN    = r_tx_en;

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Testbench for serial_tx_fifo: directed scenarios plus randomized traffic against a queue-based model.
// A short GAP_CYCLES keeps the run small; strobe spacing is checked as GAP+3.
module tb_serial_tx_fifo;
  localparam int DEPTH   = 16;
  localparam int GAP     = 20;
  localparam int SPACING = GAP + 3;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       WR_EN = 1'b0;
  logic [7:0] WR_DATA = 8'h00;
`ifdef TXFIFO_FLUSH_EN
  logic       FLUSH = 1'b0;
`endif
  logic       FULL, EMPTY, OVERFLOW, TX_EN;
  logic [4:0] LEVEL;
  logic [7:0] TX_DATA;

  int checks = 0;
  int failures = 0;

  // Reference model: queue of buffered bytes plus the earliest edge at which the pacer may pop.
  logic [7:0] m_q[$];
  int         edge_no = 0;
  int         m_idle_at = 0;
  logic [7:0] m_tx_data = 8'h00;
  logic       m_tx_en = 1'b0;
  logic       m_ovf = 1'b0;

  serial_tx_fifo #(.DEPTH_LOG2(4), .GAP_CYCLES(16'(GAP))) dut (
    .CLK(CLK), .RST_N(RST_N), .WR_DATA(WR_DATA), .WR_EN(WR_EN),
`ifdef TXFIFO_FLUSH_EN
    .FLUSH(FLUSH),
`endif
    .FULL(FULL), .EMPTY(EMPTY), .LEVEL(LEVEL), .OVERFLOW(OVERFLOW),
    .TX_DATA(TX_DATA), .TX_EN(TX_EN)
  );

  always #5 CLK = ~CLK;

  task automatic step(input logic wr, input logic [7:0] d, input logic f);
    int pre;
    logic pop;
    WR_EN = wr;
    WR_DATA = d;
`ifdef TXFIFO_FLUSH_EN
    FLUSH = f;
`endif
    @(posedge CLK);
    edge_no++;
    pre = m_q.size();
    pop = (edge_no >= m_idle_at) && (pre > 0);
    m_tx_en = pop;
    if (pop) begin
      m_tx_data = m_q.pop_front();
      m_idle_at = edge_no + SPACING;
    end
    if (f) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else if (wr) begin
      if (pre == DEPTH) m_ovf = 1'b1;
      else m_q.push_back(d);
    end
    #1;
    WR_EN = 1'b0;
`ifdef TXFIFO_FLUSH_EN
    FLUSH = 1'b0;
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < 20 * SPACING && (m_q.size() != 0 || edge_no < m_idle_at); i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    #1 RST_N = 1'b0;
    #1;
    checks++;
    if ({LEVEL, FULL, EMPTY, OVERFLOW, TX_EN} !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_flags: got lvl=%0d full=%b empty=%b ovf=%b en=%b expected 0/0/1/0/0", LEVEL, FULL, EMPTY, OVERFLOW, TX_EN);
    end
    checks++;
    if (TX_DATA !== 8'h00) begin
      failures++;
      $display("FAIL reset_tx_data: got %02h expected 00", TX_DATA);
    end
    #10 RST_N = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 8'h00, 1'b0);
      checks++;
      if ({LEVEL, EMPTY, OVERFLOW, TX_EN, TX_DATA} !== {5'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
        failures++;
        $display("FAIL idle_hold cyc %0d: got lvl=%0d empty=%b ovf=%b en=%b data=%02h expected 0/1/0/0/00", i, LEVEL, EMPTY, OVERFLOW, TX_EN, TX_DATA);
      end
    end
  endtask

  task automatic test_single();
    step(1'b1, 8'h41, 1'b0);
    checks++;
    if ({LEVEL, EMPTY, TX_EN} !== {5'd1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL single_after_write: got lvl=%0d empty=%b en=%b expected 1/0/0", LEVEL, EMPTY, TX_EN);
    end
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if ({TX_EN, TX_DATA} !== {1'b1, 8'h41}) begin
      failures++;
      $display("FAIL single_strobe: got en=%b data=%02h expected 1/41", TX_EN, TX_DATA);
    end
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if ({TX_EN, EMPTY, TX_DATA} !== {1'b0, 1'b1, 8'h41}) begin
      failures++;
      $display("FAIL single_after_strobe: got en=%b empty=%b data=%02h expected 0/1/41", TX_EN, EMPTY, TX_DATA);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int t[$];
    logic [7:0] dv[$];
    int w0;
    w0 = edge_no + 1;
    for (int i = 0; i < 3 * SPACING + 5; i++) begin
      if (i < 3) step(1'b1, 8'(i + 1), 1'b0);
      else step(1'b0, 8'h00, 1'b0);
      if (TX_EN === 1'b1) begin
        t.push_back(edge_no);
        dv.push_back(TX_DATA);
      end
    end
    checks++;
    if (t.size() != 3) begin
      failures++;
      $display("FAIL burst_count: got %0d strobes expected 3", t.size());
    end else begin
      checks++;
      if (t[0] != w0 + 1) begin
        failures++;
        $display("FAIL burst_latency: got strobe at edge %0d expected %0d", t[0], w0 + 1);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (dv[i] !== 8'(i + 1)) begin
          failures++;
          $display("FAIL burst_data %0d: got %02h expected %02h", i, dv[i], 8'(i + 1));
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (t[i] - t[i-1] != SPACING) begin
          failures++;
          $display("FAIL burst_spacing %0d: got %0d cycles expected %0d", i, t[i] - t[i-1], SPACING);
        end
      end
    end
    drain();
  endtask

  task automatic test_overflow();
    logic [7:0] got[$];
    int peak = 0;
    logic full_seen = 1'b0;
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 8'(i), 1'b0);
      if (TX_EN === 1'b1) got.push_back(TX_DATA);
      if (int'(LEVEL) > peak) peak = int'(LEVEL);
      if (FULL === 1'b1) full_seen = 1'b1;
      checks++;
      if ({LEVEL, FULL, EMPTY, OVERFLOW} !== {5'(m_q.size()), m_q.size() == DEPTH, m_q.size() == 0, m_ovf}) begin
        failures++;
        $display("FAIL ovf_fill cyc %0d: got lvl=%0d full=%b empty=%b ovf=%b expected lvl=%0d ovf=%b", i, LEVEL, FULL, EMPTY, OVERFLOW, m_q.size(), m_ovf);
      end
    end
    checks++;
    if ({5'(peak), full_seen, OVERFLOW} !== {5'd16, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL ovf_peak: got peak=%0d full_seen=%b ovf=%b expected 16/1/1", peak, full_seen, OVERFLOW);
    end
    for (int i = 0; i < 20 * SPACING && got.size() < 18; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (TX_EN === 1'b1) got.push_back(TX_DATA);
    end
    checks++;
    if (got.size() != 17) begin
      failures++;
      $display("FAIL ovf_out_count: got %0d bytes expected 17", got.size());
    end
    for (int i = 0; i < got.size() && i < 17; i++) begin
      checks++;
      if (got[i] !== 8'(i)) begin
        failures++;
        $display("FAIL ovf_out_order %0d: got %02h expected %02h", i, got[i], 8'(i));
      end
    end
    drain();
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hA0 + i), 1'b0);
    checks++;
    if (LEVEL !== 5'd5) begin
      failures++;
      $display("FAIL rst_mid_pre: got lvl=%0d expected 5", LEVEL);
    end
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({LEVEL, EMPTY, TX_EN, OVERFLOW, TX_DATA} !== {5'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL rst_mid_async: got lvl=%0d empty=%b en=%b ovf=%b data=%02h expected 0/1/0/0/00", LEVEL, EMPTY, TX_EN, OVERFLOW, TX_DATA);
    end
    m_q.delete();
    m_ovf = 1'b0;
    m_tx_en = 1'b0;
    m_tx_data = 8'h00;
    m_idle_at = 0;
    @(negedge CLK) RST_N = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 8'h00, 1'b0);
      checks++;
      if ({TX_EN, EMPTY} !== 2'b01) begin
        failures++;
        $display("FAIL rst_mid_quiet cyc %0d: got en=%b empty=%b expected 0/1", i, TX_EN, EMPTY);
      end
    end
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if ({TX_EN, TX_DATA} !== {1'b1, 8'h5A}) begin
      failures++;
      $display("FAIL rst_mid_resume: got en=%b data=%02h expected 1/5A", TX_EN, TX_DATA);
    end
    drain();
  endtask

`ifdef TXFIFO_FLUSH_EN
  task automatic test_flush();
    int pe = -1;
    int se = -1;
    logic [7:0] held;
    for (int i = 0; i < 18; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    for (int i = 0; i < 20 * SPACING && pe < 0; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (LEVEL === 5'd4) pe = edge_no;
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
    held = TX_DATA;
    checks++;
    if ({pe >= 0, LEVEL, OVERFLOW} !== {1'b1, 5'd4, 1'b1}) begin
      failures++;
      $display("FAIL flush_pre: got found=%b lvl=%0d ovf=%b expected 1/4/1", pe >= 0, LEVEL, OVERFLOW);
    end
    step(1'b1, 8'hEE, 1'b1);
    checks++;
    if ({LEVEL, EMPTY, OVERFLOW, TX_DATA} !== {5'd0, 1'b1, 1'b0, held}) begin
      failures++;
      $display("FAIL flush_clear: got lvl=%0d empty=%b ovf=%b data=%02h expected 0/1/0/%02h", LEVEL, EMPTY, OVERFLOW, TX_DATA, held);
    end
    step(1'b1, 8'h77, 1'b0);
    for (int i = 0; i < 2 * SPACING && se < 0; i++) begin
      if (TX_EN === 1'b1) se = edge_no;
      else step(1'b0, 8'h00, 1'b0);
    end
    checks++;
    if (se != pe + SPACING || TX_DATA !== 8'h77) begin
      failures++;
      $display("FAIL flush_next_strobe: got edge=%0d data=%02h expected edge=%0d data=77", se, TX_DATA, pe + SPACING);
    end
    drain();
  endtask
`endif

  task automatic test_random();
    logic f;
    for (int i = 0; i < 800; i++) begin
      f = 1'b0;
`ifdef TXFIFO_FLUSH_EN
      f = ($urandom_range(0, 99) < 2);
`endif
      step(($urandom_range(0, 99) < ((i < 300) ? 60 : 4)), 8'($urandom), f);
      checks++;
      if ({LEVEL, FULL, EMPTY, OVERFLOW, TX_EN} !== {5'(m_q.size()), m_q.size() == DEPTH, m_q.size() == 0, m_ovf, m_tx_en}) begin
        failures++;
        $display("FAIL rand_flags cyc %0d: got lvl=%0d full=%b empty=%b ovf=%b en=%b expected lvl=%0d ovf=%b en=%b", i, LEVEL, FULL, EMPTY, OVERFLOW, TX_EN, m_q.size(), m_ovf, m_tx_en);
      end
      checks++;
      if (TX_DATA !== m_tx_data) begin
        failures++;
        $display("FAIL rand_data cyc %0d: got %02h expected %02h", i, TX_DATA, m_tx_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
`ifdef TXFIFO_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
